// File: rtl/sram_sample_engine.sv
// sram_sample_engine: async-mode cellular RAM controller with a built-in periodic playback reader.
// Latency: each access is WAIT_CYCLES+1 strobe cycles plus one DONE cycle; sample_valid follows a tick by WAIT_CYCLES+3 clks.
// Backpressure: wr_req is held until wr_ack; a tick arriving while one is still pending is dropped and sets sticky overrun.
module sram_sample_engine #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 6,
  parameter int RATE_DIV    = 3175
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play_en,
  input  logic [ADDR_WIDTH-1:0] loop_end,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic [22:0]           MemAdr,
  inout  wire  [DATA_WIDTH-1:0] MemDB,
  output logic                  RamAdv,
  output logic                  RamClk,
  output logic                  RamCS,
  output logic                  MemOE,
  output logic                  MemWR,
  output logic                  RamLB,
  output logic                  RamUB
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Ordering: {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB}
  localparam logic [6:0] CTRL_IDLE  = 7'b1111111;
  localparam logic [6:0] CTRL_READ  = 7'b0000100;
  localparam logic [6:0] CTRL_WRITE = 7'b0001000;

  localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(RATE_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick_pending;
  logic [ADDR_WIDTH-1:0] play_addr;
  logic [DATA_WIDTH-1:0] wr_buf;
  logic                  db_oe;
  logic [6:0]            ctrl_q;
  logic                  wr_ack_q;
  logic                  tick;
  logic                  take_tick;
  logic                  last_strobe;

  assign tick        = play_en && (div_cnt == DIV_MAX);
  assign take_tick   = (state == S_IDLE) && tick_pending;
  assign last_strobe = (wait_cnt == WAIT_MAX);
  assign busy        = (state != S_IDLE);

  assign {RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB} = ctrl_q;
  assign MemDB = db_oe ? wr_buf : {DATA_WIDTH{1'bz}};

  // Playback rate divider, pending-tick flag and sticky overrun detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      tick_pending <= 1'b0;
      overrun      <= 1'b0;
    end else if (!play_en) begin
      div_cnt      <= '0;
      tick_pending <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        tick_pending <= 1'b1;
      end else if (take_tick) begin
        tick_pending <= 1'b0;
      end
      if (tick && tick_pending) begin
        overrun <= 1'b1;
      end
    end
  end

  // Playback address: advances after each completed read, wraps at or beyond loop_end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      play_addr <= '0;
    end else if (!play_en) begin
      play_addr <= '0;
    end else if (state == S_READ && last_strobe) begin
      play_addr <= (play_addr >= loop_end) ? '0 : play_addr + ADDR_WIDTH'(1);
    end
  end

  // Access FSM with registered RAM strobes, address, data-bus enable and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      MemAdr       <= '0;
      wr_buf       <= '0;
      db_oe        <= 1'b0;
      ctrl_q       <= CTRL_IDLE;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      wr_ack       <= 1'b0;
      wr_ack_q     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      wr_ack       <= 1'b0;
      wr_ack_q     <= wr_ack;
      case (state)
        S_IDLE: begin
          if (tick_pending) begin
            state    <= S_READ;
            MemAdr   <= 23'(play_addr);
            wait_cnt <= '0;
            ctrl_q   <= CTRL_READ;
          end else if (wr_req && !wr_ack_q) begin
            state    <= S_WRITE;
            MemAdr   <= 23'(wr_addr);
            wr_buf   <= wr_data;
            db_oe    <= 1'b1;
            wait_cnt <= '0;
            ctrl_q   <= CTRL_WRITE;
          end
        end
        S_READ: begin
          if (last_strobe) begin
            sample_out   <= MemDB;
            sample_valid <= 1'b1;
            ctrl_q       <= CTRL_IDLE;
            state        <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (last_strobe) begin
            wr_ack <= 1'b1;
            db_oe  <= 1'b0;
            ctrl_q <= CTRL_IDLE;
            state  <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
